// File: rtl/tt_vfp_fma_arb.sv
// Two-requester round-robin front end for a shared single-cycle FMA.
// Results return through a per-requester credit-guarded FWFT response FIFO.
module tt_vfp_fma_arb #(
  parameter int SIG_WIDTH = 11,
  parameter int EXP_WIDTH = 5,
  parameter int RSP_DEPTH = 3,
  localparam int RW = EXP_WIDTH + SIG_WIDTH + 1,
  localparam int FW = EXP_WIDTH + SIG_WIDTH
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic [1:0]          i_req_valid,
  output logic [1:0]          o_req_ready,
  input  logic [1:0][1:0]     i_req_op,
  input  logic [1:0][2:0]     i_req_rm,
  input  logic [1:0][RW-1:0]  i_req_a,
  input  logic [1:0][RW-1:0]  i_req_b,
  input  logic [1:0][RW-1:0]  i_req_c,
  output logic                o_fma_valid,
  output logic [1:0]          o_fma_op,
  output logic [2:0]          o_fma_rm,
  output logic [RW-1:0]       o_fma_a,
  output logic [RW-1:0]       o_fma_b,
  output logic [RW-1:0]       o_fma_c,
  input  logic [FW-1:0]       i_fma_res,
  input  logic [4:0]          i_fma_exc,
  output logic [1:0]          o_rsp_valid,
  input  logic [1:0]          i_rsp_ready,
  output logic [1:0][FW-1:0]  o_rsp_res,
  output logic [1:0][4:0]     o_rsp_exc,
  output logic                o_busy
);

  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int DW = FW + 5;

  logic       prio;
  logic       tag_valid;
  logic       tag_id;
  logic [1:0] eligible;
  logic [1:0] grant;
  logic [1:0] nonempty;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Reset gates the grant so no request is accepted while the block is held in reset.
  always_comb begin
    grant = 2'b00;
    if (i_reset_n) begin
      if (eligible == 2'b11) grant = prio ? 2'b10 : 2'b01;
      else                   grant = eligible;
    end
  end

  assign o_req_ready = grant;
  assign o_fma_valid = |grant;

  always_comb begin
    o_fma_op = '0;
    o_fma_rm = '0;
    o_fma_a  = '0;
    o_fma_b  = '0;
    o_fma_c  = '0;
    for (int i = 0; i < 2; i++) begin
      if (grant[i]) begin
        o_fma_op = i_req_op[i];
        o_fma_rm = i_req_rm[i];
        o_fma_a  = i_req_a[i];
        o_fma_b  = i_req_b[i];
        o_fma_c  = i_req_c[i];
      end
    end
  end

  // The tag remembers which requester owns the result coming back next cycle.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      prio      <= 1'b0;
      tag_valid <= 1'b0;
      tag_id    <= 1'b0;
    end else begin
      tag_valid <= |grant;
      tag_id    <= grant[1];
      if (|grant) prio <= grant[0];
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_req
    logic [CW-1:0] credit;
    logic [CW-1:0] count;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [DW-1:0] mem [RSP_DEPTH];
    logic          wr_en;
    logic          pop;

    assign eligible[g]    = i_req_valid[g] && (credit != '0);
    assign wr_en          = tag_valid && (tag_id == 1'(g));
    assign nonempty[g]    = (count != '0);
    assign pop            = nonempty[g] && i_rsp_ready[g];
    assign o_rsp_valid[g] = nonempty[g];
    assign {o_rsp_exc[g], o_rsp_res[g]} = mem[rd_ptr];

    // A credit is spent at grant and refunded at pop, so the FIFO can never overflow.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
        credit <= CW'(RSP_DEPTH);
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        case ({grant[g], pop})
          2'b10:   credit <= credit - CW'(1);
          2'b01:   credit <= credit + CW'(1);
          default: credit <= credit;
        endcase
        case ({wr_en, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
        if (wr_en) wr_ptr <= next_ptr(wr_ptr);
        if (pop)   rd_ptr <= next_ptr(rd_ptr);
      end
    end

    always_ff @(posedge i_clk) begin
      if (wr_en) mem[wr_ptr] <= {i_fma_exc, i_fma_res};
    end
  end

  assign o_busy = tag_valid || (|nonempty);

endmodule

// File: tb/tb_tt_vfp_fma_arb.sv
// Scoreboard bench for tt_vfp_fma_arb: an arbiter/credit model predicts grants,
// a behavioural FMA answers issues, and queued results are checked on pop.
module tb_tt_vfp_fma_arb;

  localparam int RW    = 17;
  localparam int FW    = 16;
  localparam int DEPTH = 3;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [1:0][1:0]     req_op;
  logic [1:0][2:0]     req_rm;
  logic [1:0][RW-1:0]  req_a, req_b, req_c;
  logic                fma_valid;
  logic [1:0]          fma_op;
  logic [2:0]          fma_rm;
  logic [RW-1:0]       fma_a, fma_b, fma_c;
  logic [FW-1:0]       fma_res;
  logic [4:0]          fma_exc;
  logic [1:0]          rsp_valid;
  logic [1:0]          rsp_ready;
  logic [1:0][FW-1:0]  rsp_res;
  logic [1:0][4:0]     rsp_exc;
  logic                busy;

  typedef struct {
    logic [20:0] d;
    int          vis;
  } rsp_t;

  rsp_t sb0[$];
  rsp_t sb1[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  logic m_prio = 1'b0;

  always #5 clk = ~clk;

  tt_vfp_fma_arb #(.SIG_WIDTH(11), .EXP_WIDTH(5), .RSP_DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_op(req_op), .i_req_rm(req_rm),
    .i_req_a(req_a), .i_req_b(req_b), .i_req_c(req_c),
    .o_fma_valid(fma_valid), .o_fma_op(fma_op), .o_fma_rm(fma_rm),
    .o_fma_a(fma_a), .o_fma_b(fma_b), .o_fma_c(fma_c),
    .i_fma_res(fma_res), .i_fma_exc(fma_exc),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_res(rsp_res), .o_rsp_exc(rsp_exc),
    .o_busy(busy)
  );

  // Stand-in FMA: exact FP16 answers for 1.0*2.0+/-0.5, a deterministic hash otherwise.
  function automatic logic [20:0] fake_fma(input logic [1:0] op, input logic [2:0] rm,
                                           input logic [16:0] a, input logic [16:0] b,
                                           input logic [16:0] c);
    logic [15:0] r;
    logic [4:0]  x;
    if (rm == 3'd0 && a == 17'h08000 && b == 17'h08400 && c == 17'h07C00) begin
      case (op)
        2'd0:    r = 16'h4100;
        2'd1:    r = 16'h3E00;
        2'd2:    r = 16'hBE00;
        default: r = 16'hC100;
      endcase
      x = 5'd0;
    end else begin
      r = a[15:0] ^ {b[7:0], b[15:8]} ^ (c[15:0] + 16'h1234) ^ {op, rm, 11'h0};
      x = a[16:12] ^ b[4:0] ^ c[16:12] ^ {op, rm};
    end
    return {x, r};
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fma_valid) {fma_exc, fma_res} <= fake_fma(fma_op, fma_rm, fma_a, fma_b, fma_c);
    else           {fma_exc, fma_res} <= 21'($urandom);
  end

  logic [1:0]  m_elig, m_gnt;
  logic [55:0] m_issue;
  rsp_t        m_head, m_new;
  int          m_sz0, m_sz1;
  logic        m_hv;

  // Reference model and scoreboard, evaluated mid-cycle once inputs are settled.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb0.delete();
      sb1.delete();
      m_prio = 1'b0;
    end else begin
      m_sz0 = sb0.size();
      m_sz1 = sb1.size();
      m_elig[0] = req_valid[0] && (m_sz0 < DEPTH);
      m_elig[1] = req_valid[1] && (m_sz1 < DEPTH);
      if (m_elig == 2'b11) m_gnt = m_prio ? 2'b10 : 2'b01;
      else                 m_gnt = m_elig;
      checks++;
      if (req_ready !== m_gnt) begin
        errors++;
        $display("[TB] FAIL req_ready cyc=%0d got=%b want=%b", cyc, req_ready, m_gnt);
      end
      checks++;
      if (fma_valid !== (|m_gnt)) begin
        errors++;
        $display("[TB] FAIL fma_valid cyc=%0d got=%b want=%b", cyc, fma_valid, |m_gnt);
      end
      m_issue = m_gnt[0] ? {req_op[0], req_rm[0], req_a[0], req_b[0], req_c[0]} :
                m_gnt[1] ? {req_op[1], req_rm[1], req_a[1], req_b[1], req_c[1]} : '0;
      checks++;
      if ({fma_op, fma_rm, fma_a, fma_b, fma_c} !== m_issue) begin
        errors++;
        $display("[TB] FAIL fma_issue cyc=%0d got=%h want=%h", cyc,
                 {fma_op, fma_rm, fma_a, fma_b, fma_c}, m_issue);
      end
      checks++;
      if (busy !== ((m_sz0 + m_sz1) != 0)) begin
        errors++;
        $display("[TB] FAIL busy cyc=%0d got=%b want=%b", cyc, busy, (m_sz0 + m_sz1) != 0);
      end
      for (int i = 0; i < 2; i++) begin
        if (i == 0) m_hv = (m_sz0 > 0) && (sb0[0].vis <= cyc);
        else        m_hv = (m_sz1 > 0) && (sb1[0].vis <= cyc);
        checks++;
        if (rsp_valid[i] !== m_hv) begin
          errors++;
          $display("[TB] FAIL rsp_valid[%0d] cyc=%0d got=%b want=%b", i, cyc, rsp_valid[i], m_hv);
        end
        if (m_hv) begin
          m_head = (i == 0) ? sb0[0] : sb1[0];
          checks++;
          if ({rsp_exc[i], rsp_res[i]} !== m_head.d) begin
            errors++;
            $display("[TB] FAIL rsp_data[%0d] cyc=%0d got=%h want=%h", i, cyc,
                     {rsp_exc[i], rsp_res[i]}, m_head.d);
          end
          if (rsp_ready[i]) begin
            if (i == 0) void'(sb0.pop_front());
            else        void'(sb1.pop_front());
          end
        end
      end
      for (int i = 0; i < 2; i++) begin
        if (m_gnt[i]) begin
          m_new.d   = fake_fma(req_op[i], req_rm[i], req_a[i], req_b[i], req_c[i]);
          m_new.vis = cyc + 2;
          if (i == 0) sb0.push_back(m_new);
          else        sb1.push_back(m_new);
          m_prio = (i == 0);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      req_op[i] = 2'($urandom);
      req_rm[i] = 3'($urandom);
      req_a[i]  = 17'($urandom);
      req_b[i]  = 17'($urandom);
      req_c[i]  = 17'($urandom);
    end
  endtask

  task automatic idle(input int n);
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    repeat (n) step();
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = 2'b00;
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    step();
    req_valid = 2'b11;
    @(negedge clk);
    checks++;
    if ({req_ready, fma_valid, rsp_valid, busy} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got=%b want=000000", {req_ready, fma_valid, rsp_valid, busy});
    end
    checks++;
    if ({fma_op, fma_rm, fma_a, fma_b, fma_c} !== 56'h0) begin
      errors++;
      $display("[TB] FAIL reset_fma_fields got=%h want=0", {fma_op, fma_rm, fma_a, fma_b, fma_c});
    end
    step();
    rst_n     = 1'b1;
    req_valid = 2'b00;
    @(negedge clk);
    checks++;
    if ({req_ready, fma_valid, rsp_valid, busy} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL idle_outputs got=%b want=000000", {req_ready, fma_valid, rsp_valid, busy});
    end
    step();
    req_valid = 2'b01;
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("[TB] FAIL first_grant got=%b want=01", req_ready);
    end
    idle(5);
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_seq [6] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
    do_reset();
    rsp_ready = 2'b11;
    for (int k = 0; k < 6; k++) begin
      step();
      req_valid = 2'b11;
      @(negedge clk);
      checks++;
      if (req_ready !== exp_seq[k]) begin
        errors++;
        $display("[TB] FAIL rr_grant k=%0d got=%b want=%b", k, req_ready, exp_seq[k]);
      end
    end
    idle(6);
  endtask

  task automatic test_single_stream();
    int seen = 0;
    rsp_ready = 2'b11;
    for (int k = 0; k < 8; k++) begin
      step();
      req_valid = 2'b01;
      @(negedge clk);
      checks++;
      if (req_ready !== 2'b01) begin
        errors++;
        $display("[TB] FAIL stream_grant k=%0d got=%b want=01", k, req_ready);
      end
      if (rsp_valid[0]) seen++;
    end
    for (int k = 0; k < 6; k++) begin
      step();
      req_valid = 2'b00;
      @(negedge clk);
      if (rsp_valid[0]) seen++;
    end
    checks++;
    if (seen !== 8) begin
      errors++;
      $display("[TB] FAIL stream_rsp_count got=%0d want=8", seen);
    end
    idle(2);
  endtask

  task automatic test_backpressure();
    logic [1:0] want;
    do_reset();
    rsp_ready = 2'b10;
    for (int k = 0; k < 12; k++) begin
      step();
      req_valid = 2'b11;
      @(negedge clk);
      want = (k < 5) ? ((k % 2 == 0) ? 2'b01 : 2'b10) : 2'b10;
      checks++;
      if (req_ready !== want) begin
        errors++;
        $display("[TB] FAIL bp_grant k=%0d got=%b want=%b", k, req_ready, want);
      end
    end
    step();
    req_valid = 2'b01;
    rsp_ready = 2'b11;
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b00) begin
      errors++;
      $display("[TB] FAIL bp_no_credit got=%b want=00", req_ready);
    end
    step();
    req_valid = 2'b01;
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("[TB] FAIL bp_regrant got=%b want=01", req_ready);
    end
    idle(8);
  endtask

  task automatic test_fp16();
    logic [20:0] exp_fp [2] = '{{5'd0, 16'h4100}, {5'd0, 16'hC100}};
    logic [1:0]  ops [2]    = '{2'd0, 2'd3};
    int idx = 0;
    rsp_ready = 2'b11;
    for (int k = 0; k < 2; k++) begin
      step();
      req_valid = 2'b10;
      req_op[1] = ops[k];
      req_rm[1] = 3'd0;
      req_a[1]  = 17'h08000;
      req_b[1]  = 17'h08400;
      req_c[1]  = 17'h07C00;
      @(negedge clk);
      checks++;
      if (req_ready !== 2'b10) begin
        errors++;
        $display("[TB] FAIL fp16_grant k=%0d got=%b want=10", k, req_ready);
      end
    end
    for (int k = 0; k < 8; k++) begin
      step();
      req_valid = 2'b00;
      @(negedge clk);
      if (rsp_valid[1] && idx < 2) begin
        checks++;
        if ({rsp_exc[1], rsp_res[1]} !== exp_fp[idx]) begin
          errors++;
          $display("[TB] FAIL fp16_result idx=%0d got=%h want=%h", idx,
                   {rsp_exc[1], rsp_res[1]}, exp_fp[idx]);
        end
        idx++;
      end
    end
    checks++;
    if (idx !== 2) begin
      errors++;
      $display("[TB] FAIL fp16_rsp_count got=%0d want=2", idx);
    end
  endtask

  task automatic test_reset_midflight();
    int cnt0 = 0;
    int cnt1 = 0;
    rsp_ready = 2'b01;
    for (int k = 0; k < 3; k++) begin
      step();
      req_valid = 2'b10;
      @(negedge clk);
    end
    step();
    req_valid = 2'b00;
    @(negedge clk);
    checks++;
    if ({rsp_valid, busy} !== 3'b101) begin
      errors++;
      $display("[TB] FAIL pre_reset_state got=%b want=101", {rsp_valid, busy});
    end
    #1;
    do_reset();
    rsp_ready = 2'b11;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 2'b00) begin
        errors++;
        $display("[TB] FAIL stale_rsp k=%0d got=%b want=00", k, rsp_valid);
      end
      step();
    end
    rsp_ready = 2'b00;
    for (int k = 0; k < 8; k++) begin
      step();
      req_valid = 2'b11;
      @(negedge clk);
      cnt0 += int'(req_ready[0]);
      cnt1 += int'(req_ready[1]);
    end
    checks++;
    if (cnt0 !== DEPTH || cnt1 !== DEPTH) begin
      errors++;
      $display("[TB] FAIL post_reset_credit got=%0d/%0d want=%0d/%0d", cnt0, cnt1, DEPTH, DEPTH);
    end
    idle(8);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    req_op    = '0;
    req_rm    = '0;
    req_a     = '0;
    req_b     = '0;
    req_c     = '0;
    test_reset();
    test_round_robin();
    test_single_stream();
    test_backpressure();
    test_fp16();
    test_reset_midflight();
    idle(4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/tt_vfp_fma_arb.md
TT_VFP_FMA_ARB -- requirements
Module: tt_vfp_fma_arb

Interface
REQ-001 Parameters SHALL be:
- SIG_WIDTH, 11, significand width.
- EXP_WIDTH, 5, exponent width.
- RSP_DEPTH, 3, response FIFO entries and credits per requester.

REQ-002 Local widths SHALL be RW = EXP_WIDTH+SIG_WIDTH+1 (recoded operand) and FW = EXP_WIDTH+SIG_WIDTH (standard result).

REQ-003 Ports SHALL be:
- i_clk  in  1  clock
- i_reset_n  in  1  reset, asynchronous, active-low
- i_req_valid  in  2  per-requester request valid
- o_req_ready  out  2  per-requester accept
- i_req_op  in  2x2  per-requester op (0 madd, 1 msub, 2 nmsub, 3 nmadd)
- i_req_rm  in  2x3  per-requester rounding mode
- i_req_a, i_req_b, i_req_c  in  2xRW each  recoded operands
- o_fma_valid  out  1  issue strobe to FMA
- o_fma_op  out  2  issued op
- o_fma_rm  out  3  issued rounding mode
- o_fma_a, o_fma_b, o_fma_c  out  RW each  issued operands
- i_fma_res  in  FW  FMA result, valid exactly one cycle after o_fma_valid
- i_fma_exc  in  5  FMA flags, same timing as i_fma_res
- o_rsp_valid  out  2  per-requester response valid
- i_rsp_ready  in  2  per-requester response accept
- o_rsp_res  out  2xFW  per-requester result
- o_rsp_exc  out  2x5  per-requester flags
- o_busy  out  1  any op in flight or buffered

Function
REQ-004 Request i SHALL be eligible iff i_req_valid[i]=1 and credit[i]>0.
REQ-005 At most one requester SHALL be granted per cycle; o_req_ready SHALL be one-hot or zero, and ready[i] SHALL depend on valid[i] (grant only to a valid requester).
REQ-006 Arbitration SHALL be round-robin: prio pointer selects the preferred requester; if only one is eligible it is granted; after a grant to i, prio SHALL become 1-i; with no grant, prio SHALL hold.
REQ-007 On a grant, o_fma_valid SHALL be 1 in the same cycle, and o_fma_op/rm/a/b/c SHALL equal the granted requester's inputs combinationally; with no grant, o_fma_valid=0 and operand outputs SHALL be 0.
REQ-008 A 1-deep tag register {valid, id} SHALL capture each grant; in the following cycle, when tag valid, i_fma_res/i_fma_exc SHALL be written to FIFO[id].
REQ-009 Each response FIFO SHALL be RSP_DEPTH deep, in-order, first-word-fall-through: o_rsp_valid[i] = FIFO non-empty, and o_rsp_res/o_rsp_exc SHALL show the head entry; pop on valid & ready.
REQ-010 Latency: a request accepted in cycle T SHALL appear at o_rsp_valid in cycle T+2 when the FIFO is empty.
REQ-011 credit[i] SHALL be clog2(RSP_DEPTH+1) bits: decrement on grant to i, increment on pop of FIFO[i], unchanged when both occur; credit SHALL never exceed RSP_DEPTH or underflow, so FIFO overflow is impossible.
REQ-012 With RSP_DEPTH >= 3 and i_rsp_ready held at 1, a single requester SHALL sustain one grant per cycle.
REQ-013 i_fma_exc SHALL be stored and returned unmodified; flags from one requester SHALL never appear at the other.
REQ-014 o_busy SHALL be 1 when the tag is valid or either FIFO is non-empty.
REQ-015 Writing FIFO[id] and popping the same FIFO in the same cycle SHALL both take effect.

Reset
REQ-016 Reset SHALL force prio=0, tag valid=0, both FIFOs empty, credit=RSP_DEPTH, o_req_ready=0, o_fma_valid=0, o_rsp_valid=0, o_busy=0, and o_fma_op/rm/a/b/c=0.
REQ-017 Reset asserted mid-operation SHALL discard in-flight and buffered results; no stale response SHALL emerge after deassertion.

Verification
REQ-018 Reset release, both requesters idle -> all outputs 0; first request is granted on its first valid cycle.
REQ-019 Both requesters valid for 6 cycles, i_rsp_ready=2'b11 -> grant sequence 0,1,0,1,0,1; each response arrives 2 cycles after its grant.
REQ-020 Requester 0 alone issues 8 ops, i_rsp_ready[0]=1 -> 8 consecutive grants; 8 responses in issue order.
REQ-021 i_rsp_ready[0]=0 with both requesters valid -> requester 0 receives 3 grants, then ready[0] stays 0 while requester 1 receives one grant per cycle; raise ready[0] -> 3 results in order, then requester 0 is granted again.
REQ-022 FP16, recoded a=1.0, b=2.0, c=0.5, rm=0: op=0 -> res 16'h4100, exc 0; op=3 -> res 16'hC100, exc 0.
REQ-023 Reset pulsed with an op in the tag register and 2 entries in FIFO[1] -> after release, o_rsp_valid=0 and credit=3 for both requesters.
